key_remap_table: RTL and testbench
==================================

Name: key_remap_table

Overview:
Parametrised successor to the fixed two-table key-mapping RAM in the keyboard front end. It holds CHANNELS independent one-hot remap tables, KEY_BITS entries each, and translates physical key vectors to logical key vectors with registered output. It adds a sequential learn mode that lets the user rebind keys at run time. Each table always remains a permutation.

Parameters:
KEY_BITS, 7, number of physical keys per channel; table depth and entry width (one-hot)
CHANNELS, 2, independent tables (ch0 = note keys, ch1 = length keys by convention)
TIMEOUT_CYCLES, 100000000, learn-mode inactivity limit in clk cycles (>=2)
CH_W (localparam), max(1,clog2(CHANNELS)), channel select width
TO_W (localparam), clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  CHANNELS*KEY_BITS  physical key vectors; channel c at [c*KEY_BITS +: KEY_BITS]
key_out  out  CHANNELS*KEY_BITS  translated logical one-hot vectors, same packing
key_valid  out  CHANNELS  1 = key_out[c] holds a valid translated key
learn_start  in  1  one-cycle request to enter learn mode
learn_ch  in  CH_W  channel to relearn, sampled with learn_start
learn_cancel  in  1  abort learn while waiting for a key
restore  in  1  synchronous reload of identity map in all channels
learn_busy  out  1  high whenever the FSM is not in IDLE
learn_done  out  1  one-cycle pulse on commit
learn_abort  out  1  one-cycle pulse on cancel, timeout or restore-during-learn

Behaviour:
- Reset (async, rst=1): mem[c][i] = 1<<i for all c, i (identity). FSM=IDLE. All outputs 0.
- Translation, latency 1: if key_in[c] is exactly one-hot with bit i set, the next cycle drives key_out[c]=mem[c][i] and key_valid[c]=1.
- Translation, other inputs: all-zero or multi-hot key_in[c] gives key_out[c]=0 and key_valid[c]=0 next cycle.
- Translation while learn_busy: the learned channel outputs 0/invalid. Other channels translate normally.
- FSM states: IDLE, WAIT_SRC, REL_SRC, WAIT_DST, COMMIT.
- IDLE -> WAIT_SRC: on learn_start with learn_ch < CHANNELS; latch ch and clear the timeout counter. learn_ch >= CHANNELS is ignored.
- WAIT_SRC: on a one-hot key_in[ch], latch index p, go to REL_SRC. Multi-hot input is ignored.
- REL_SRC: on key_in[ch]==0, go to WAIT_DST.
- WAIT_DST: on one-hot key_in[ch], latch index q, go to COMMIT.
- COMMIT (1 cycle): swap mem[ch][p] and mem[ch][q]; p==q leaves the table unchanged. Pulse learn_done and go to IDLE.
- Timeout counter: runs in WAIT_SRC, REL_SRC and WAIT_DST, and resets on every state change. At TIMEOUT_CYCLES it pulses learn_abort and goes to IDLE with the table unchanged.
- learn_cancel: honoured only in the WAIT_SRC, REL_SRC and WAIT_DST states, where it pulses learn_abort and goes to IDLE. It is ignored in COMMIT, so the commit completes.
- learn_start while busy: ignored.
- restore: reloads identity next edge. If busy, it also pulses learn_abort and forces IDLE. restore in the COMMIT cycle wins: identity is loaded and learn_done is not pulsed.
- Priority: rst > restore > COMMIT write > cancel/timeout > key events.
- Invariant: each mem[c] is always a permutation of the one-hot vectors.
- Storage is flops, not BRAM, because reset initialises every entry.

Test Plan:
- Reset, then key_in ch0=7'b0000100: the next cycle gives key_out ch0=7'b0000100, key_valid[0]=1. A multi-hot 7'b0000110 gives 0 and valid=0.
- Learn ch0, sequence press 7'b0000001, release, press 7'b0001000 (p=0, q=3):
  - learn_done pulses once and busy drops.
  - key_in 7'b0000001 then gives 7'b0001000, and key_in 7'b0001000 gives 7'b0000001.
  - ch1 is unchanged throughout.
- Learn ch1 with p==q=2: learn_done pulses and the table stays identity. learn_start asserted mid-learn is ignored.
- TIMEOUT_CYCLES=16, learn_start then no key: learn_abort pulses exactly 16 cycles after entering WAIT_SRC, the table is unchanged, and busy=0.
- learn_cancel in WAIT_DST gives abort with no swap.
- Swap in ch0, then restore asserted in the COMMIT cycle: identity is loaded, learn_abort=1, learn_done=0.
- Async rst asserted mid-WAIT_DST, between edges: outputs go to 0 immediately, and the FSM is IDLE with the identity table.

Source files
------------

// File: rtl/key_remap_table.sv
// Per-channel one-hot key remap tables with registered translation
// and a press/release/press learn sequence that swaps two entries.
module key_remap_table #(
  parameter int KEY_BITS = 7,
  parameter int CHANNELS = 2,
  parameter int TIMEOUT_CYCLES = 100000000,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*KEY_BITS-1:0] key_in,
  output logic [CHANNELS*KEY_BITS-1:0] key_out,
  output logic [CHANNELS-1:0]          key_valid,
  input  logic                         learn_start,
  input  logic [CH_W-1:0]              learn_ch,
  input  logic                         learn_cancel,
  input  logic                         restore,
  output logic                         learn_busy,
  output logic                         learn_done,
  output logic                         learn_abort
);

  localparam int IX_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_SRC, REL_SRC, WAIT_DST, COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [KEY_BITS-1:0] mem [CHANNELS][KEY_BITS];
  logic [KEY_BITS-1:0] key_a [CHANNELS];
  logic [KEY_BITS-1:0] sel;
  logic [CH_W-1:0]     ch_q;
  logic [IX_W-1:0]     p_q, q_q;
  logic [TO_W-1:0]     cnt_q;
  logic                waiting, tmo;
  logic                start_ok, latch_p, latch_q, swap;
  logic                done_d, abort_d;

  function automatic logic is_hot(input logic [KEY_BITS-1:0] v);
    return (v != '0) && ((v & (v - KEY_BITS'(1))) == '0);
  endfunction

  function automatic logic [IX_W-1:0] enc(input logic [KEY_BITS-1:0] v);
    logic [IX_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_BITS; i++)
      if (v[i]) r = IX_W'(i);
    return r;
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      key_a[c] = key_in[c*KEY_BITS +: KEY_BITS];
  end

  assign sel        = key_a[ch_q];
  assign learn_busy = (state_q != IDLE);
  assign waiting    = (state_q == WAIT_SRC) || (state_q == REL_SRC) ||
                      (state_q == WAIT_DST);
  assign tmo        = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    latch_p  = 1'b0;
    latch_q  = 1'b0;
    swap     = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    if (restore) begin
      state_d = IDLE;
      abort_d = learn_busy;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (learn_start && (int'(learn_ch) < CHANNELS)) begin
            state_d  = WAIT_SRC;
            start_ok = 1'b1;
          end
        end
        COMMIT: begin
          swap    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          if (learn_cancel || tmo) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end else if (state_q == WAIT_SRC && is_hot(sel)) begin
            state_d = REL_SRC;
            latch_p = 1'b1;
          end else if (state_q == REL_SRC && sel == '0) begin
            state_d = WAIT_DST;
          end else if (state_q == WAIT_DST && is_hot(sel)) begin
            state_d = COMMIT;
            latch_q = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      p_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      key_out     <= '0;
      key_valid   <= '0;
      learn_done  <= 1'b0;
      learn_abort <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < KEY_BITS; i++)
          mem[c][i] <= KEY_BITS'(1) << i;
    end else begin
      state_q     <= state_d;
      learn_done  <= done_d;
      learn_abort <= abort_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (waiting)
        cnt_q <= cnt_q + TO_W'(1);
      if (start_ok) ch_q <= learn_ch;
      if (latch_p)  p_q  <= enc(sel);
      if (latch_q)  q_q  <= enc(sel);
      if (restore) begin
        for (int c = 0; c < CHANNELS; c++)
          for (int i = 0; i < KEY_BITS; i++)
            mem[c][i] <= KEY_BITS'(1) << i;
      end else if (swap) begin
        mem[ch_q][p_q] <= mem[ch_q][q_q];
        mem[ch_q][q_q] <= mem[ch_q][p_q];
      end
      // the channel being relearned is muted until the FSM is back in IDLE
      for (int c = 0; c < CHANNELS; c++) begin
        if ((learn_busy && ch_q == CH_W'(c)) || !is_hot(key_a[c])) begin
          key_out[c*KEY_BITS +: KEY_BITS] <= '0;
          key_valid[c]                    <= 1'b0;
        end else begin
          key_out[c*KEY_BITS +: KEY_BITS] <= mem[c][enc(key_a[c])];
          key_valid[c]                    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_remap_table.sv
// Bench for key_remap_table: permutation-table model checked every
// cycle plus directed learn/restore/timeout/reset scenarios.
module tb_key_remap_table;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] key_in = '0;
  logic [13:0] key_out;
  logic [1:0]  key_valid;
  logic        learn_start = 1'b0;
  logic        learn_ch = 1'b0;
  logic        learn_cancel = 1'b0;
  logic        restore = 1'b0;
  logic        learn_busy, learn_done, learn_abort;

  int checks = 0;
  int errors = 0;

  key_remap_table #(
    .KEY_BITS(7), .CHANNELS(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .key_valid(key_valid), .learn_start(learn_start),
    .learn_ch(learn_ch), .learn_cancel(learn_cancel),
    .restore(restore), .learn_busy(learn_busy),
    .learn_done(learn_done), .learn_abort(learn_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: perm[c][i] is the output bit index for physical key i.
  int          perm [2][7];
  bit          mbusy, mon;
  int          lch, ph, mp, mq, tc, tmp;
  logic [6:0]  mk;
  logic [13:0] exp_out;
  logic [1:0]  exp_val;
  bit          exp_done, exp_abort;

  function automatic int idx(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 7; i++) perm[c][i] = i;
      mbusy = 0; lch = 0; ph = 0; tc = 0;
      exp_out = '0; exp_val = '0; exp_done = 0; exp_abort = 0;
      mon = 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mk = key_in[c*7 +: 7];
        if ((mbusy && lch == c) || $countones(mk) != 1) begin
          exp_out[c*7 +: 7] = '0;
          exp_val[c] = 1'b0;
        end else begin
          exp_out[c*7 +: 7] = 7'(1) << perm[c][idx(mk)];
          exp_val[c] = 1'b1;
        end
      end
      exp_done = 0;
      exp_abort = 0;
      if (restore) begin
        exp_abort = mbusy;
        mbusy = 0;
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 7; i++) perm[c][i] = i;
      end else if (mbusy) begin
        mk = key_in[lch*7 +: 7];
        if (ph == 3) begin
          tmp = perm[lch][mp];
          perm[lch][mp] = perm[lch][mq];
          perm[lch][mq] = tmp;
          exp_done = 1; mbusy = 0;
        end else if (learn_cancel || tc == 15) begin
          exp_abort = 1; mbusy = 0;
        end else if (ph == 0 && $countones(mk) == 1) begin
          mp = idx(mk); ph = 1; tc = 0;
        end else if (ph == 1 && mk == 0) begin
          ph = 2; tc = 0;
        end else if (ph == 2 && $countones(mk) == 1) begin
          mq = idx(mk); ph = 3; tc = 0;
        end else begin
          tc++;
        end
      end else if (learn_start && int'(learn_ch) < 2) begin
        mbusy = 1; lch = int'(learn_ch); ph = 0; tc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("cyc key_out", 32'(key_out), 32'(exp_out));
      chk("cyc key_valid", 32'(key_valid), 32'(exp_val));
      chk("cyc busy", 32'(learn_busy), 32'(mbusy));
      chk("cyc done", 32'(learn_done), 32'(exp_done));
      chk("cyc abort", 32'(learn_abort), 32'(exp_abort));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic keys(input logic [6:0] k0, input logic [6:0] k1);
    key_in = {k1, k0};
  endtask

  task automatic start(input logic ch);
    learn_ch = ch;
    learn_start = 1'b1;
    tick();
    learn_start = 1'b0;
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    #11 rst = 1'b0;
    chk("rst key_out", 32'(key_out), 0);
    chk("rst valid", 32'(key_valid), 0);
    chk("rst busy", 32'(learn_busy), 0);

    keys(7'b0000100, 7'b0);
    tick();
    chk("xl ch0", 32'(key_out[6:0]), 32'(7'b0000100));
    chk("xl valid", 32'(key_valid), 2'b01);
    keys(7'b0000110, 7'b0100000);
    tick();
    chk("multi ch0", 32'(key_out[6:0]), 0);
    chk("multi valid", 32'(key_valid), 2'b10);
    chk("xl ch1", 32'(key_out[13:7]), 32'(7'b0100000));

    keys(7'b0, 7'b0);
    start(1'b0);
    chk("learn busy", 32'(learn_busy), 1);
    keys(7'b0000001, 7'b0000010);
    tick();
    chk("muted ch0", 32'(key_valid), 2'b10);
    chk("ch1 during", 32'(key_out[13:7]), 32'(7'b0000010));
    keys(7'b0, 7'b0);
    tick();
    keys(7'b0001000, 7'b0);
    tick();
    chk("commit no done", 32'(learn_done), 0);
    keys(7'b0, 7'b0);
    tick();
    chk("done pulse", 32'(learn_done), 1);
    chk("done busy", 32'(learn_busy), 0);
    tick();
    chk("done once", 32'(learn_done), 0);
    keys(7'b0000001, 7'b0);
    tick();
    chk("swap p", 32'(key_out[6:0]), 32'(7'b0001000));
    keys(7'b0001000, 7'b0);
    tick();
    chk("swap q", 32'(key_out[6:0]), 32'(7'b0000001));

    keys(7'b0, 7'b0);
    start(1'b1);
    keys(7'b0000001, 7'b0000100);
    learn_ch = 1'b0;
    learn_start = 1'b1;
    tick();
    learn_start = 1'b0;
    chk("ch0 while ch1", 32'(key_out[6:0]), 32'(7'b0001000));
    keys(7'b0, 7'b0);
    tick();
    keys(7'b0, 7'b0000100);
    tick();
    keys(7'b0, 7'b0);
    tick();
    chk("p==q done", 32'(learn_done), 1);
    keys(7'b0, 7'b0000100);
    tick();
    chk("p==q ident", 32'(key_out[13:7]), 32'(7'b0000100));

    keys(7'b0, 7'b0);
    start(1'b1);
    n = 0;
    while (!learn_abort && n < 40) begin
      tick();
      n++;
    end
    chk("timeout cycles", 32'(n), 16);
    chk("timeout busy", 32'(learn_busy), 0);
    keys(7'b0, 7'b0000010);
    tick();
    chk("timeout table", 32'(key_out[13:7]), 32'(7'b0000010));

    keys(7'b0, 7'b0);
    start(1'b0);
    keys(7'b0000010, 7'b0);
    tick();
    keys(7'b0, 7'b0);
    tick();
    learn_cancel = 1'b1;
    tick();
    learn_cancel = 1'b0;
    chk("cancel abort", 32'(learn_abort), 1);
    chk("cancel busy", 32'(learn_busy), 0);
    keys(7'b0000010, 7'b0);
    tick();
    chk("cancel noswap", 32'(key_out[6:0]), 32'(7'b0000010));

    keys(7'b0, 7'b0);
    start(1'b0);
    keys(7'b0000100, 7'b0);
    tick();
    keys(7'b0, 7'b0);
    tick();
    keys(7'b0100000, 7'b0);
    tick();
    keys(7'b0, 7'b0);
    restore = 1'b1;
    tick();
    restore = 1'b0;
    chk("rest abort", 32'(learn_abort), 1);
    chk("rest done", 32'(learn_done), 0);
    chk("rest busy", 32'(learn_busy), 0);
    keys(7'b0000001, 7'b0);
    tick();
    chk("rest ident0", 32'(key_out[6:0]), 32'(7'b0000001));
    keys(7'b0000100, 7'b0);
    tick();
    chk("rest ident2", 32'(key_out[6:0]), 32'(7'b0000100));

    keys(7'b0, 7'b0);
    start(1'b1);
    keys(7'b0, 7'b0000001);
    tick();
    keys(7'b0000001, 7'b0);
    tick();
    chk("pre-rst out", 32'(key_out[6:0]), 32'(7'b0000001));
    #1 rst = 1'b1;
    #1;
    chk("arst key_out", 32'(key_out), 0);
    chk("arst valid", 32'(key_valid), 0);
    chk("arst busy", 32'(learn_busy), 0);
    #2 rst = 1'b0;
    keys(7'b0000001, 7'b0000010);
    tick();
    chk("arst ch1", 32'(key_out[13:7]), 32'(7'b0000010));
    chk("arst ch0", 32'(key_out[6:0]), 32'(7'b0000001));
    chk("arst valid2", 32'(key_valid), 2'b11);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
